// File: rtl/rx_port_mux_if.sv
// rx_port_mux_if: bus bundle for the ingress aggregation mux.
//   Upstream side : four per-port MAC receive FIFO pairs (frame pointer + byte data).
//   Downstream side: shared byte FIFO (sfifo) and pointer FIFO (ptr_sfifo), plus the drop counter.
// Modports:
//   master - the mux itself (drives read strobes, write strobes and drop_cnt).
//   slave  - the surrounding FIFOs / environment.
interface rx_port_mux_if;
    logic [3:0]  rx_ptr_empty;   // per-port pointer FIFO empty
    logic [3:0]  rx_ptr_rd;      // per-port pointer FIFO read strobe
    logic [63:0] rx_ptr_dout;    // port p at [16p+15:16p]: {prert[3:0], err, len[10:0]}
    logic [3:0]  rx_data_rd;     // per-port data FIFO read strobe
    logic [31:0] rx_data_dout;   // port p at [8p+7:8p], valid the cycle after rd
    logic        sfifo_wr;
    logic [7:0]  sfifo_din;
    logic        sfifo_afull;    // fewer than 2048 bytes free
    logic        ptr_sfifo_wr;
    logic [19:0] ptr_sfifo_din;  // {prert, src one-hot, 1'b0, len}
    logic        ptr_sfifo_full;
    logic [15:0] drop_cnt;       // saturating dropped-frame count

    modport master (
        input  rx_ptr_empty, rx_ptr_dout, rx_data_dout, sfifo_afull, ptr_sfifo_full,
        output rx_ptr_rd, rx_data_rd, sfifo_wr, sfifo_din, ptr_sfifo_wr, ptr_sfifo_din,
               drop_cnt
    );

    modport slave (
        output rx_ptr_empty, rx_ptr_dout, rx_data_dout, sfifo_afull, ptr_sfifo_full,
        input  rx_ptr_rd, rx_data_rd, sfifo_wr, sfifo_din, ptr_sfifo_wr, ptr_sfifo_din,
               drop_cnt
    );
endinterface

// File: rtl/rx_port_mux.sv
// rx_port_mux: round-robin ingress aggregation of four MAC receive FIFO pairs into the shared
// byte FIFO and pointer FIFO feeding the frame processor. Whole frames are serialized; the
// pointer is written only after the last data byte. Frames with an out-of-range length
// (< 60 or > 1518) are drained and dropped; drop_cnt counts them (saturating).
// Ports:
//   clk  - clock
//   rstn - synchronous active-low reset
//   bus  - rx_port_mux_if.master (upstream FIFO pairs, sfifo, ptr_sfifo, drop_cnt)
// Build option:
//   RXMUX_DROP_ERR_EN - when defined, frames whose pointer error bit [11] is set are also
//                       drained, dropped and counted; otherwise the error bit is ignored.
module rx_port_mux (
    input  logic          clk,
    input  logic          rstn,
    rx_port_mux_if.master bus
);

`ifdef RXMUX_DROP_ERR_EN
    localparam logic DropErr = 1'b1;
`else
    localparam logic DropErr = 1'b0;
`endif
    localparam logic [10:0] MinLen = 11'd60;
    localparam logic [10:0] MaxLen = 11'd1518;

    typedef enum logic [2:0] {
        StIdle, StPtr, StLatch, StData, StFlush, StCommit
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  rr_q, rr_d;
    logic [10:0] len_q, len_d;
    logic [10:0] cnt_q, cnt_d;
    logic [3:0]  prert_q, prert_d;
    logic        drop_q, drop_d;
    logic        flush_q, flush_d;
    logic        rd_d1_q, rd_d1_d;
    logic        sfifo_wr_q, sfifo_wr_d;
    logic [7:0]  sfifo_din_q, sfifo_din_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic [3:0]  req;
    logic [3:0]  sel_onehot;
    logic        gnt_valid;
    logic [1:0]  gnt;
    logic [15:0] ptr_word;
    logic [7:0]  data_byte;

    assign req        = ~bus.rx_ptr_empty;
    assign sel_onehot = 4'b0001 << sel_q;
    assign ptr_word   = bus.rx_ptr_dout[{sel_q, 4'b0000} +: 16];
    assign data_byte  = bus.rx_data_dout[{sel_q, 3'b000} +: 8];

    // Cyclic search from rr_q; iterating downwards lets the nearest requester win.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = rr_q;
        for (int i = 3; i >= 0; i--) begin
            if (req[rr_q + 2'(i)]) begin
                gnt_valid = 1'b1;
                gnt       = rr_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        sel_d            = sel_q;
        rr_d             = rr_q;
        len_d            = len_q;
        cnt_d            = cnt_q;
        prert_d          = prert_q;
        drop_d           = drop_q;
        flush_d          = flush_q;
        drop_cnt_d       = drop_cnt_q;
        rd_d1_d          = 1'b0;
        bus.rx_ptr_rd    = 4'b0000;
        bus.rx_data_rd   = 4'b0000;
        bus.ptr_sfifo_wr = 1'b0;
        bus.ptr_sfifo_din = 20'h0_0000;

        // Write pipeline: rd -> (data valid) -> registered write, gated by the frame's drop flag.
        sfifo_wr_d  = rd_d1_q & ~drop_q;
        sfifo_din_d = rd_d1_q ? data_byte : 8'h00;

        unique case (state_q)
            StIdle: begin
                // Downstream space is only checked here; afull leaves room for a max frame.
                if (gnt_valid && !bus.sfifo_afull && !bus.ptr_sfifo_full) begin
                    sel_d   = gnt;
                    state_d = StPtr;
                end
            end
            StPtr: begin
                bus.rx_ptr_rd = sel_onehot;
                state_d       = StLatch;
            end
            StLatch: begin
                len_d   = ptr_word[10:0];
                prert_d = ptr_word[15:12];
                drop_d  = (ptr_word[10:0] < MinLen) || (ptr_word[10:0] > MaxLen) ||
                          (ptr_word[11] && DropErr);
                cnt_d   = ptr_word[10:0];
                flush_d = 1'b0;
                state_d = (ptr_word[10:0] == 11'd0) ? StFlush : StData;
            end
            StData: begin
                // Dropped frames are drained too, so the next pointer lines up with its data.
                bus.rx_data_rd = sel_onehot;
                rd_d1_d        = 1'b1;
                if (cnt_q == 11'd1) begin
                    state_d = StFlush;
                end else begin
                    cnt_d = cnt_q - 11'd1;
                end
            end
            StFlush: begin
                if (flush_q) begin
                    state_d = StCommit;
                end else begin
                    flush_d = 1'b1;
                end
            end
            StCommit: begin
                if (!drop_q) begin
                    bus.ptr_sfifo_wr  = 1'b1;
                    bus.ptr_sfifo_din = {prert_q, sel_onehot, 1'b0, len_q};
                end else if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
                rr_d    = sel_q + 2'd1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            sel_q       <= 2'd0;
            rr_q        <= 2'd0;
            len_q       <= 11'd0;
            cnt_q       <= 11'd0;
            prert_q     <= 4'd0;
            drop_q      <= 1'b0;
            flush_q     <= 1'b0;
            rd_d1_q     <= 1'b0;
            sfifo_wr_q  <= 1'b0;
            sfifo_din_q <= 8'h00;
            drop_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_q        <= rr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            prert_q     <= prert_d;
            drop_q      <= drop_d;
            flush_q     <= flush_d;
            rd_d1_q     <= rd_d1_d;
            sfifo_wr_q  <= sfifo_wr_d;
            sfifo_din_q <= sfifo_din_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign bus.sfifo_wr  = sfifo_wr_q;
    assign bus.sfifo_din = sfifo_din_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rx_port_mux.sv
module tb_rx_port_mux;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    rx_port_mux_if bus ();

    rx_port_mux dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

`ifdef RXMUX_DROP_ERR_EN
    localparam bit DropErr = 1'b1;
`else
    localparam bit DropErr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Frame store, written only by the stimulus block.
    int         fr_len[$];
    bit         fr_err[$];
    logic [3:0] fr_prert[$];
    int         fr_start[$];
    logic [7:0] all_bytes[$];
    int         stg_frame[$];
    int         stg_port[$];

    // Upstream FIFO model, owned by the posedge block.
    logic [15:0] pq [4][$];
    logic [7:0]  dq [4][$];
    int          stg_rd = 0;
    logic [3:0]  rd_ptr_s = 4'b0;
    logic [3:0]  rd_dat_s = 4'b0;

    // Downstream capture, owned by the negedge block.
    logic [7:0]  got_bytes[$];
    int          got_stamp[$];
    logic [19:0] got_ptr[$];
    int          ptr_wr_stamp[$];
    int          ptr_rd_stamp[$];
    int          ptr_rd_port[$];
    int          rd_cnt [4] = '{0, 0, 0, 0};

    // Reference model state.
    int          pend [4][$];
    int          m_rr = 0;
    int          m_drops = 0;
    logic [7:0]  exp_bytes[$];
    logic [19:0] exp_ptr[$];
    int          gb = 0;
    int          gp = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rstn) begin
            for (int p = 0; p < 4; p++) begin
                pq[p].delete();
                dq[p].delete();
            end
            bus.rx_ptr_dout  <= '0;
            bus.rx_data_dout <= '0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (rd_ptr_s[p] && pq[p].size() > 0) bus.rx_ptr_dout[p*16 +: 16] <= pq[p].pop_front();
                if (rd_dat_s[p] && dq[p].size() > 0) bus.rx_data_dout[p*8 +: 8] <= dq[p].pop_front();
            end
            for (int i = stg_rd; i < stg_frame.size(); i++) begin
                for (int k = 0; k < fr_len[stg_frame[i]]; k++)
                    dq[stg_port[i]].push_back(all_bytes[fr_start[stg_frame[i]] + k]);
                pq[stg_port[i]].push_back({fr_prert[stg_frame[i]], fr_err[stg_frame[i]],
                                           11'(fr_len[stg_frame[i]])});
            end
            stg_rd <= stg_frame.size();
        end
    end

    always @(negedge clk) begin
        rd_ptr_s <= bus.rx_ptr_rd;
        rd_dat_s <= bus.rx_data_rd;
        for (int p = 0; p < 4; p++) begin
            bus.rx_ptr_empty[p] <= (pq[p].size() == 0);
            if (bus.rx_data_rd[p]) rd_cnt[p] <= rd_cnt[p] + 1;
            if (bus.rx_ptr_rd[p]) begin
                ptr_rd_stamp.push_back(cyc);
                ptr_rd_port.push_back(p);
            end
        end
        if (bus.sfifo_wr) begin
            got_bytes.push_back(bus.sfifo_din);
            got_stamp.push_back(cyc);
        end
        if (bus.ptr_sfifo_wr) begin
            got_ptr.push_back(bus.ptr_sfifo_din);
            ptr_wr_stamp.push_back(cyc);
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic add_frame(int p, int len, bit err, logic [3:0] prert);
        int idx;
        idx = fr_len.size();
        fr_start.push_back(all_bytes.size());
        for (int k = 0; k < len; k++) all_bytes.push_back(8'($urandom));
        fr_len.push_back(len);
        fr_err.push_back(err);
        fr_prert.push_back(prert);
        pend[p].push_back(idx);
        stg_port.push_back(p);
        stg_frame.push_back(idx);
    endtask

    // Serve pending frames port by port in round-robin order from m_rr.
    task automatic model_run();
        bit found;
        int p;
        int f;
        do begin
            found = 1'b0;
            p = 0;
            for (int i = 0; i < 4; i++) begin
                if (!found && pend[(m_rr + i) % 4].size() > 0) begin
                    p = (m_rr + i) % 4;
                    found = 1'b1;
                end
            end
            if (found) begin
                f = pend[p].pop_front();
                if (fr_len[f] >= 60 && fr_len[f] <= 1518 && !(DropErr && fr_err[f])) begin
                    for (int k = 0; k < fr_len[f]; k++) exp_bytes.push_back(all_bytes[fr_start[f] + k]);
                    exp_ptr.push_back({fr_prert[f], 4'(1 << p), 1'b0, 11'(fr_len[f])});
                end else if (m_drops < 65535) begin
                    m_drops++;
                end
                m_rr = (p + 1) % 4;
            end
        end while (found);
    endtask

    function automatic bit busy();
        bit b;
        b = (stg_rd < stg_frame.size());
        for (int p = 0; p < 4; p++) if (pq[p].size() > 0 || dq[p].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_drain(string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (n < 20000 && busy()) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/drain_timeout"}, 32'(n < 20000), 32'd1);
        repeat (12) @(negedge clk);
    endtask

    task automatic compare_batch(string tag);
        int n_got;
        int n_ptr;
        int mism;
        n_got = got_bytes.size() - gb;
        n_ptr = got_ptr.size() - gp;
        chk({tag, "/nbytes"}, 32'(n_got), 32'(exp_bytes.size()));
        mism = 0;
        for (int i = 0; i < exp_bytes.size() && i < n_got; i++)
            if (got_bytes[gb + i] !== exp_bytes[i]) mism++;
        chk({tag, "/byte_mismatches"}, 32'(mism), 32'd0);
        chk({tag, "/nptr"}, 32'(n_ptr), 32'(exp_ptr.size()));
        for (int i = 0; i < exp_ptr.size() && i < n_ptr; i++)
            chk($sformatf("%s/ptr%0d", tag, i), 32'(got_ptr[gp + i]), 32'(exp_ptr[i]));
        chk({tag, "/drop_cnt"}, 32'(bus.drop_cnt), 32'(m_drops));
        gb = got_bytes.size();
        gp = got_ptr.size();
        exp_bytes.delete();
        exp_ptr.delete();
    endtask

    task automatic model_reset();
        for (int p = 0; p < 4; p++) pend[p].delete();
        m_rr = 0;
        m_drops = 0;
        exp_bytes.delete();
        exp_ptr.delete();
        gb = got_bytes.size();
        gp = got_ptr.size();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        int pr;
        int n;
        int p;
        int rc1;
        int rc3;
        int rc;
        int len;
        int r;
        bus.sfifo_afull    = 1'b0;
        bus.ptr_sfifo_full = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst/ptr_rd", 32'(bus.rx_ptr_rd), 32'd0);
        chk("rst/data_rd", 32'(bus.rx_data_rd), 32'd0);
        chk("rst/sfifo_wr", 32'(bus.sfifo_wr), 32'd0);
        chk("rst/sfifo_din", 32'(bus.sfifo_din), 32'd0);
        chk("rst/ptr_wr", 32'(bus.ptr_sfifo_wr), 32'd0);
        chk("rst/ptr_din", 32'(bus.ptr_sfifo_din), 32'd0);
        chk("rst/drop_cnt", 32'(bus.drop_cnt), 32'd0);
        rstn = 1'b1;
        model_reset();
        @(negedge clk);

        // Single 64-byte frame on port 2 with latency checks
        pr = ptr_rd_stamp.size();
        add_frame(2, 64, 1'b0, 4'h0);
        model_run();
        wait_drain("t1");
        chk("t1/src_port", 32'(ptr_rd_port[pr]), 32'd2);
        chk("t1/ptr_const", 32'(got_ptr[gp]), 32'h0_4040);
        chk("t1/rd_to_wr", 32'(got_stamp[gb] - ptr_rd_stamp[pr]), 32'd4);
        chk("t1/wr_span", 32'(got_stamp[gb + 63] - got_stamp[gb]), 32'd63);
        chk("t1/ptr_after_data", 32'(ptr_wr_stamp[gp] - got_stamp[gb]), 32'd64);
        compare_batch("t1");

        // Four ports pending from rr 0, port 0 re-queued while port 1 is served
        do_reset();
        for (int i = 0; i < 4; i++) add_frame(i, 100, 1'b0, 4'($urandom));
        n = 0;
        while (n < 5000 && !bus.rx_ptr_rd[1]) begin
            @(negedge clk);
            n++;
        end
        chk("t2/port1_served", 32'(n < 5000), 32'd1);
        add_frame(0, 100, 1'b0, 4'($urandom));
        model_run();
        wait_drain("t2");
        compare_batch("t2");

        // Runt then giant: drained and dropped, then a minimum-size frame forwarded
        rc1 = rd_cnt[1];
        rc3 = rd_cnt[3];
        add_frame(1, 40, 1'b0, 4'h3);
        add_frame(3, 1600, 1'b0, 4'h5);
        model_run();
        wait_drain("t3");
        chk("t3/runt_reads", 32'(rd_cnt[1] - rc1), 32'd40);
        chk("t3/giant_reads", 32'(rd_cnt[3] - rc3), 32'd1600);
        compare_batch("t3");
        add_frame(2, 60, 1'b0, 4'h9);
        model_run();
        wait_drain("t3b");
        compare_batch("t3b");

        // Error bit set on a valid-length frame
        add_frame(0, 200, 1'b1, 4'hA);
        model_run();
        wait_drain("t4");
        compare_batch("t4");

        // Randomized mix including runts, giants, zero length and error flags
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) len = $urandom_range(0, 59);
            else if (r == 1) len = $urandom_range(1519, 1700);
            else len = $urandom_range(60, 400);
            add_frame($urandom_range(0, 3), len, 1'($urandom), 4'($urandom));
        end
        model_run();
        wait_drain("t5");
        compare_batch("t5");

        // Backpressure: afull, then ptr_sfifo_full, hold off the pointer read
        pr = ptr_rd_stamp.size();
        bus.sfifo_afull = 1'b1;
        add_frame(0, 64, 1'b0, 4'h1);
        repeat (20) @(negedge clk);
        chk("t6/afull_no_rd", 32'(ptr_rd_stamp.size() - pr), 32'd0);
        bus.sfifo_afull = 1'b0;
        @(negedge clk);
        chk("t6/rd_one_cycle", 32'(bus.rx_ptr_rd), 32'h1);
        model_run();
        wait_drain("t6");
        compare_batch("t6");
        pr = ptr_rd_stamp.size();
        bus.ptr_sfifo_full = 1'b1;
        add_frame(3, 80, 1'b0, 4'h2);
        repeat (15) @(negedge clk);
        chk("t6/full_no_rd", 32'(ptr_rd_stamp.size() - pr), 32'd0);
        bus.ptr_sfifo_full = 1'b0;
        model_run();
        wait_drain("t6b");
        compare_batch("t6b");

        // Reset in the middle of a 500-byte transfer
        p = $urandom_range(0, 3);
        rc = rd_cnt[p];
        add_frame(p, 500, 1'b0, 4'h7);
        n = 0;
        while (n < 2000 && (rd_cnt[p] - rc) < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t7/transfer_started", 32'(n < 2000), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("t7/ptr_rd", 32'(bus.rx_ptr_rd), 32'd0);
        chk("t7/data_rd", 32'(bus.rx_data_rd), 32'd0);
        chk("t7/sfifo_wr", 32'(bus.sfifo_wr), 32'd0);
        chk("t7/ptr_wr", 32'(bus.ptr_sfifo_wr), 32'd0);
        chk("t7/drop_cnt", 32'(bus.drop_cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        @(negedge clk);
        pr = ptr_rd_stamp.size();
        add_frame(3, $urandom_range(60, 200), 1'b0, 4'($urandom));
        add_frame(0, $urandom_range(60, 200), 1'b0, 4'($urandom));
        model_run();
        wait_drain("t7b");
        chk("t7b/rr_from_zero", 32'(ptr_rd_port[pr]), 32'd0);
        compare_batch("t7b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
